// File: rtl/uart_apb_pkg.sv
// Shared types and register map for the UART APB initiator.
package uart_apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StRdwait
    } apb_state_e;

    localparam logic [31:0] REG_DIV      = 32'h0000_0000;
    localparam logic [31:0] REG_PARITY   = 32'h0000_0004;
    localparam logic [31:0] REG_STOP     = 32'h0000_0008;
    localparam logic [31:0] REG_ERR_RX   = 32'h0000_000C;
    localparam logic [31:0] REG_ERR_DROP = 32'h0000_0010;

endpackage

// File: rtl/uart_apb_init_seq.sv
// Post-reset init write sequencer: tracks which of DIV/PARITY/STOP is next and supplies
// its address and data; the master FSM advances it when an init write finishes.
module uart_apb_init_seq
    import uart_apb_pkg::*;
#(
    parameter logic [31:0] INIT_DIV    = 32'd868,
    parameter logic [31:0] INIT_PARITY = 32'd0,
    parameter logic [31:0] INIT_STOP   = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic        pending,
    output logic [31:0] init_addr,
    output logic [31:0] init_data,
    output logic        init_done
);

    logic [1:0] init_idx_q, init_idx_d;

    assign pending   = (init_idx_q != 2'd3);
    assign init_done = ~pending;

    always_comb begin
        init_idx_d = init_idx_q;
        if (advance && pending) begin
            init_idx_d = init_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx_q <= 2'd0;
        end else begin
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        init_addr = REG_DIV;
        init_data = INIT_DIV;
        case (init_idx_q)
            2'd1: begin
                init_addr = REG_PARITY;
                init_data = INIT_PARITY;
            end
            2'd2: begin
                init_addr = REG_STOP;
                init_data = INIT_STOP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_apb_master.sv
// APB initiator for the UART register block: runs the init writes, then serves single commands.
// Optional ACCESS-phase timeout is enabled by defining UART_APB_TIMEOUT_EN.
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter logic [31:0] INIT_DIV       = 32'd868,
    parameter logic [31:0] INIT_PARITY    = 32'd0,
    parameter logic [31:0] INIT_STOP      = 32'd1,
    parameter int unsigned RDATA_LAT      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);

    apb_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        is_init_q, is_init_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        init_pending;
    logic        init_advance;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic        tmo_hit;

    uart_apb_init_seq #(
        .INIT_DIV    (INIT_DIV),
        .INIT_PARITY (INIT_PARITY),
        .INIT_STOP   (INIT_STOP)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .advance   (init_advance),
        .pending   (init_pending),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_done (init_done)
    );

`ifdef UART_APB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == StSetup) begin
            tmo_cnt_d = '0;
        end else if (state_q == StAccess && !pready) begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit = (state_q == StAccess) && !pready &&
                     (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        is_init_d    = is_init_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = 1'b0;
        init_advance = 1'b0;
        cmd_ready    = 1'b0;

        case (state_q)
            StIdle: begin
                if (init_pending) begin
                    addr_d    = init_addr;
                    wdata_d   = init_data;
                    write_d   = 1'b1;
                    is_init_d = 1'b1;
                    state_d   = StSetup;
                end else begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        addr_d    = cmd_addr;
                        wdata_d   = cmd_wdata;
                        write_d   = cmd_write;
                        is_init_d = 1'b0;
                        state_d   = StSetup;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    if (write_q) begin
                        state_d = StIdle;
                        if (is_init_q) begin
                            init_advance = 1'b1;
                        end else begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = '0;
                        end
                    end else if (RDATA_LAT == 0) begin
                        state_d     = StIdle;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = prdata;
                    end else begin
                        state_d = StRdwait;
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    if (is_init_q) begin
                        init_advance = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            StRdwait: begin
                // Slave registers prdata, so it is valid one cycle after pready.
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = prdata;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            is_init_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            is_init_q   <= is_init_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign psel      = (state_q == StSetup) || (state_q == StAccess);
    assign penable   = (state_q == StAccess);
    assign pwrite    = write_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Randomized bench for uart_apb_master: a wait-state APB slave with registered prdata, and a
// register-array model that predicts every response, its latency and the init write sequence.
module tb_uart_apb_master;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;

    always #5 clk = ~clk;

    uart_apb_master #(
        .INIT_DIV       (32'd868),
        .INIT_PARITY    (32'd0),
        .INIT_STOP      (32'd1),
        .RDATA_LAT      (1),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // APB slave: wait_n low-pready ACCESS cycles, stall holds pready low forever.
    logic [31:0] slv_mem [8];
    int          acc_cnt = 0;
    int          wait_n  = 0;
    bit          stall   = 1'b0;

    assign pready = psel && penable && !stall && (acc_cnt >= wait_n);

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready) begin
            if (pwrite) slv_mem[paddr[4:2]] <= pwdata;
            else        prdata <= slv_mem[paddr[4:2]];
        end
    end

    // Bus monitor.
    logic [31:0] snap_addr, snap_wdata, last_addr;
    logic        snap_write, last_write;
    int          last_comp_cyc = 0;
    int          rsp_cnt = 0;
    logic [63:0] wlog[$];

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (!rst) begin
            if (penable && !psel) check_eq("penable_without_psel", penable, 1'b0);
            if (psel && !penable) begin
                snap_addr  = paddr;
                snap_wdata = pwdata;
                snap_write = pwrite;
            end
            if (psel && penable) begin
                check_eq("apb_addr_stable", paddr, snap_addr);
                check_eq("apb_wdata_stable", pwdata, snap_wdata);
                check_eq("apb_write_stable", pwrite, snap_write);
            end
            if (psel && penable && pready) begin
                last_addr     = paddr;
                last_write    = pwrite;
                last_comp_cyc = cyc;
                if (pwrite) wlog.push_back({paddr, pwdata});
            end
        end
    end

    // Reference model.
    logic [31:0] exp_mem [8];
    logic [31:0] init_vals [3] = '{32'd868, 32'd0, 32'd1};
    int          n_cmds = 0;

    task automatic wait_init(input string tag);
        int viol = 0;
        int r0;
        bit done = 1'b0;
        logic [63:0] exp_w;
        r0 = rsp_cnt;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (init_done) begin
                done = 1'b1;
                break;
            end
            if (cmd_ready) viol++;
        end
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_done_timing"}, cyc, last_comp_cyc + 1);
        check_eq({tag, "_ready_early"}, viol, 0);
        check_eq({tag, "_rsp_pulses"}, rsp_cnt - r0, 0);
        check_eq({tag, "_write_count"}, wlog.size(), 3);
        for (int k = 0; k < 3; k++) begin
            exp_w = {32'(k * 4), init_vals[k]};
            if (k < wlog.size()) check_eq({tag, "_write"}, wlog[k], exp_w);
            exp_mem[k] = init_vals[k];
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit stuck);
        int          hs;
        int          exp_lat;
        bit          ok;
        logic [2:0]  idx;
        logic [31:0] exp_rd;
        idx     = addr[4:2];
        exp_lat = stuck ? 2 + TIMEOUT : 3 + waits + (wr ? 0 : 1);
        exp_rd  = (stuck || wr) ? 32'd0 : exp_mem[idx];
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        wait_n    = waits;
        stall     = stuck;
        ok        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("cmd_accepted", ok, 1'b1);
        hs = cyc;
        n_cmds++;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rsp_seen", ok, 1'b1);
        check_eq("rsp_latency", cyc - hs, exp_lat);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", rsp_err, stuck);
        check_eq("idle_gap_ready", cmd_ready, 1'b1);
        if (!stuck) begin
            check_eq("apb_addr", last_addr, addr);
            check_eq("apb_write", last_write, wr);
        end
        @(negedge clk);
        check_eq("rsp_pulse_width", rsp_valid, 1'b0);
        stall = 1'b0;
        if (wr && !stuck) exp_mem[idx] = wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r0;
        bit          seen;
        logic [31:0] a;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            slv_mem[i] = '0;
            exp_mem[i] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, init_done}, 0);
        check_eq("rst_paddr", paddr, 0);
        check_eq("rst_pwdata", pwdata, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        wlog.delete();
        rst = 1'b0;
        wait_init("init");

        do_cmd(1'b1, 32'h0, 32'h1B2, 0, 1'b0);
        do_cmd(1'b1, 32'h4, 32'd5, 0, 1'b0);
        do_cmd(1'b0, 32'h4, 32'd0, 0, 1'b0);
        do_cmd(1'b1, 32'h8, 32'hA5A5_0001, 5, 1'b0);
        do_cmd(1'b0, 32'h8, 32'd0, 5, 1'b0);
        do_cmd(1'b0, 32'h1C, 32'd0, 2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 7)) << 2;
            do_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0);
        end

`ifdef UART_APB_TIMEOUT_EN
        do_cmd(1'b0, 32'h4, 32'd0, 0, 1'b1);
        do_cmd(1'b1, 32'hC, 32'd77, 0, 1'b0);
        do_cmd(1'b0, 32'hC, 32'd0, 1, 1'b0);
`endif

        // Reset in the middle of an ACCESS phase.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'h55;
        stall     = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (psel && penable) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rst_mid_access_reached", seen, 1'b1);
        r0  = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_psel_penable", {psel, penable}, 2'b00);
        check_eq("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_mid_init_done", init_done, 1'b0);
        check_eq("rst_mid_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        wlog.delete();
        stall = 1'b0;
        rst   = 1'b0;
        wait_init("reinit");
        check_eq("rst_mid_no_rsp", rsp_cnt - r0, 0);
        do_cmd(1'b0, 32'h10, 32'd0, 1, 1'b0);

        repeat (2) @(negedge clk);
        check_eq("rsp_count", rsp_cnt, n_cmds);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
